// File: rtl/prim_usb_rx_pkg.sv
// prim_usb_rx_pkg: USB line-state encoding shared by the differential receiver blocks
package prim_usb_rx_pkg;
  typedef enum logic [1:0] {
    LsSE0 = 2'b00,
    LsJ   = 2'b01,
    LsK   = 2'b10,
    LsSE1 = 2'b11
  } usb_line_state_e;
  localparam usb_line_state_e UsbLsIdle = LsJ;
endpackage

// File: rtl/prim_buf.sv
// prim_buf: plain buffer cell kept as a distinct instance for observability taps
module prim_buf #(
  parameter int Width = 1
) (
  input  logic [Width-1:0] in_i,
  output logic [Width-1:0] out_o
);
  assign out_o = in_i;
endmodule

// File: rtl/prim_flop_2sync.sv
// prim_flop_2sync: two-flop synchroniser with a synchronous clear back to the reset value
module prim_flop_2sync #(
  parameter int               Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);
  logic [Width-1:0] s1_q, s2_q;
  // two-stage capture; clear forces both stages so stale pin state cannot leak out
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= ResetValue;
      s2_q <= ResetValue;
    end else if (clr_i) begin
      s1_q <= ResetValue;
      s2_q <= ResetValue;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end
  assign q_o = s2_q;
endmodule

// File: rtl/prim_usb_rx_glitch_filt.sv
// prim_usb_rx_glitch_filt: vector glitch filter, output follows input only after Depth identical differing samples
module prim_usb_rx_glitch_filt #(
  parameter int               Width    = 2,
  parameter int               Depth    = 3,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);
  localparam int CW = $clog2(Depth + 1);
  logic [Width-1:0] q_q, cand_q;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  // a sample matching the pending candidate extends the run, any other differing value restarts it at 1
  always_comb cnt_nxt = (cnt_q != '0 && d_i == cand_q) ? cnt_q + 1'b1 : CW'(1);
  // commit the candidate once the run reaches Depth; a return to the filtered value drops the run
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q    <= ResetVal;
      cand_q <= ResetVal;
      cnt_q  <= '0;
    end else if (clr_i) begin
      q_q    <= ResetVal;
      cand_q <= ResetVal;
      cnt_q  <= '0;
    end else if (d_i == q_q) begin
      cnt_q <= '0;
    end else if (cnt_nxt == CW'(Depth)) begin
      q_q   <= d_i;
      cnt_q <= '0;
    end else begin
      cnt_q  <= cnt_nxt;
      cand_q <= d_i;
    end
  end
  assign q_o = q_q;
endmodule

// File: rtl/prim_usb_diff_rx_filt.sv
// prim_usb_diff_rx_filt: USB D+/D- sync, joint glitch filter, J/K decode and bus-reset detect; PRIM_USB_RX_SE1_ERR_EN adds a sticky SE1 flag
module prim_usb_diff_rx_filt import prim_usb_rx_pkg::*; #(
  parameter int FilterDepth = 3,
  parameter int ResetCycles = 8,
  parameter int CalibW      = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              input_pi,
  input  logic              input_ni,
  input  logic              input_en_i,
  input  logic [CalibW-1:0] calibration_i,
  output logic [1:0]        line_state_o,
  output logic              rx_d_o,
  output logic              se0_long_o,
  output logic              se1_err_o,
  input  logic              se1_err_clr_i,
  output logic              usb_diff_rx_obs_o
);
  localparam int SW = $clog2(ResetCycles + 1);
  logic [1:0]      sync_ls, filt_ls;
  usb_line_state_e ls;
  logic            rx_q;
  logic [SW-1:0]   se0_q, se0_d;
  logic            unused_calib;
  assign unused_calib = ^calibration_i;
  prim_flop_2sync #(
    .Width      (2),
    .ResetValue (UsbLsIdle)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (!input_en_i),
    .d_i    ({input_ni, input_pi}),
    .q_o    (sync_ls)
  );
  prim_usb_rx_glitch_filt #(
    .Width    (2),
    .Depth    (FilterDepth),
    .ResetVal (UsbLsIdle)
  ) u_filt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (!input_en_i),
    .d_i    (sync_ls),
    .q_o    (filt_ls)
  );
  assign ls           = usb_line_state_e'(filt_ls);
  assign line_state_o = filt_ls;
  assign rx_d_o       = (ls == LsJ) ? 1'b1 : (ls == LsK) ? 1'b0 : rx_q;
  // remember the last J/K decision so SE0/SE1 intervals hold the data bit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rx_q <= 1'b1;
    else         rx_q <= input_en_i ? rx_d_o : 1'b1;
  end
  always_comb se0_d = (!input_en_i || ls != LsSE0) ? '0 :
                      (se0_q == SW'(ResetCycles)) ? se0_q : se0_q + 1'b1;
  // saturating count of consecutive filtered SE0 cycles
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) se0_q <= '0;
    else         se0_q <= se0_d;
  end
  assign se0_long_o = (se0_q == SW'(ResetCycles));
`ifdef PRIM_USB_RX_SE1_ERR_EN
  logic se1_q;
  // sticky SE1 flag; a fresh SE1 takes priority over a simultaneous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) se1_q <= 1'b0;
    else         se1_q <= (ls == LsSE1) | (se1_q & ~se1_err_clr_i);
  end
  assign se1_err_o = se1_q;
`else
  logic unused_se1_clr;
  assign unused_se1_clr = se1_err_clr_i;
  assign se1_err_o      = 1'b0;
`endif
  prim_buf #(.Width(1)) u_obs (
    .in_i  (rx_d_o),
    .out_o (usb_diff_rx_obs_o)
  );
`ifndef SYNTHESIS
  a_depth: assert property (@(posedge clk_i) FilterDepth >= 1);
  a_reset: assert property (@(posedge clk_i) ResetCycles >= 1);
  a_known: assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown(line_state_o));
`endif
endmodule

// File: tb/tb_prim_usb_diff_rx_filt.sv
// tb_prim_usb_diff_rx_filt: directed table plus cycle-exact sequences for the USB diff receiver filter
module tb_prim_usb_diff_rx_filt;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dp = 1'b1, dn = 1'b0, en = 1'b1, clr = 1'b0;
  logic [31:0] calib = 32'h1234_5678;
  logic [1:0]  ls;
  logic        rx, se0_long, se1_err, obs;
  int          n_chk = 0, n_fail = 0;
`ifdef PRIM_USB_RX_SE1_ERR_EN
  localparam bit Se1En = 1'b1;
`else
  localparam bit Se1En = 1'b0;
`endif

  prim_usb_diff_rx_filt #(.FilterDepth(3), .ResetCycles(8), .CalibW(32)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .input_pi          (dp),
    .input_ni          (dn),
    .input_en_i        (en),
    .calibration_i     (calib),
    .line_state_o      (ls),
    .rx_d_o            (rx),
    .se0_long_o        (se0_long),
    .se1_err_o         (se1_err),
    .se1_err_clr_i     (clr),
    .usb_diff_rx_obs_o (obs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] pins;
    int         hold;
    logic [1:0] e_ls;
    logic       e_rx;
    logic       e_long;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pins(input logic [1:0] v);
    {dn, dp} = v;
  endtask

  initial begin
    tbl[0] = '{2'b01, 7, 2'b01, 1'b1, 1'b0};
    tbl[1] = '{2'b10, 7, 2'b10, 1'b0, 1'b0};
    tbl[2] = '{2'b00, 7, 2'b00, 1'b0, 1'b0};
    tbl[3] = '{2'b01, 7, 2'b01, 1'b1, 1'b0};
    tbl[4] = '{2'b00, 7, 2'b00, 1'b1, 1'b0};
    tbl[5] = '{2'b11, 7, 2'b11, 1'b1, 1'b0};
    tbl[6] = '{2'b10, 7, 2'b10, 1'b0, 1'b0};
    tbl[7] = '{2'b11, 7, 2'b11, 1'b0, 1'b0};
    tbl[8] = '{2'b01, 7, 2'b01, 1'b1, 1'b0};

    pins(2'b01);
    #12;
    chk("rst_ls", 32'(ls), 32'h1);
    chk("rst_rx", 32'(rx), 32'h1);
    chk("rst_long", 32'(se0_long), 32'h0);
    chk("rst_se1", 32'(se1_err), 32'h0);
    chk("rst_obs", 32'(obs), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    chk("first_ls", 32'(ls), 32'h1);
    chk("first_rx", 32'(rx), 32'h1);

    for (int i = 0; i < 9; i++) begin
      pins(tbl[i].pins);
      tick(tbl[i].hold);
      chk($sformatf("tbl%0d_ls", i), 32'(ls), 32'(tbl[i].e_ls));
      chk($sformatf("tbl%0d_rx", i), 32'(rx), 32'(tbl[i].e_rx));
      chk($sformatf("tbl%0d_obs", i), 32'(obs), 32'(tbl[i].e_rx));
      chk($sformatf("tbl%0d_long", i), 32'(se0_long), 32'(tbl[i].e_long));
    end

    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("se1_cleared", 32'(se1_err), 32'h0);

    pins(2'b10);
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      chk($sformatf("klat%0d_ls", k), 32'(ls), (k >= 5) ? 32'h2 : 32'h1);
      chk($sformatf("klat%0d_rx", k), 32'(rx), (k >= 5) ? 32'h0 : 32'h1);
      chk($sformatf("klat%0d_obs", k), 32'(obs), (k >= 5) ? 32'h0 : 32'h1);
    end
    pins(2'b01);
    tick(8);

    pins(2'b10);
    tick(2);
    pins(2'b01);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      chk($sformatf("kglitch%0d", k), 32'({ls, rx, se0_long}), 32'b0110);
    end
    pins(2'b00);
    tick(2);
    pins(2'b01);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      chk($sformatf("se0glitch%0d", k), 32'({ls, rx, se0_long}), 32'b0110);
    end

    pins(2'b00);
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      chk($sformatf("se0_%0d_ls", k), 32'(ls), (k >= 5) ? 32'h0 : 32'h1);
      chk($sformatf("se0_%0d_long", k), 32'(se0_long), (k >= 13) ? 32'h1 : 32'h0);
    end
    pins(2'b01);
    for (int k = 21; k <= 27; k++) begin
      tick(1);
      chk($sformatf("se0end%0d_ls", k), 32'(ls), (k >= 25) ? 32'h1 : 32'h0);
      chk($sformatf("se0end%0d_long", k), 32'(se0_long), (k < 26) ? 32'h1 : 32'h0);
    end
    tick(4);

    pins(2'b00);
    tick(10);
    chk("en_pre_ls", 32'(ls), 32'h0);
    en = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      chk($sformatf("endis%0d_ls", k), 32'(ls), 32'h1);
      chk($sformatf("endis%0d_rx", k), 32'(rx), 32'h1);
      chk($sformatf("endis%0d_long", k), 32'(se0_long), 32'h0);
    end
    en = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      chk($sformatf("reen%0d_ls", k), 32'(ls), (k >= 5) ? 32'h0 : 32'h1);
      chk($sformatf("reen%0d_long", k), 32'(se0_long), (k >= 13) ? 32'h1 : 32'h0);
    end
    pins(2'b01);
    tick(8);

    pins(2'b11);
    tick(4);
    pins(2'b01);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      chk($sformatf("se1_%0d", k + 4), 32'(se1_err), (Se1En && k + 4 >= 6) ? 32'h1 : 32'h0);
    end
    chk("se1_back_ls", 32'(ls), 32'h1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("se1_clr", 32'(se1_err), 32'h0);

    pins(2'b10);
    tick(7);
    chk("pre_arst_ls", 32'(ls), 32'h2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ls", 32'(ls), 32'h1);
    chk("arst_rx", 32'(rx), 32'h1);
    chk("arst_obs", 32'(obs), 32'h1);
    #10;
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prim_usb_diff_rx_filt.md
Name: prim_usb_diff_rx_filt

Overview:
- Clocked, parametrised USB differential receiver front end.
- Synchronises raw D+/D- into `clk_i` and applies a joint glitch filter to the 2-bit line state.
- Decodes J/K/SE0/SE1, recovers the differential data bit, and detects long SE0 (bus reset).
- Sits between the USB pad pair and the usbdev line-state/NRZI logic.

Parameters:
- FilterDepth, 3: consecutive identical synchronised samples needed before the filtered line state changes; must be >= 1.
- ResetCycles, 8: saturating SE0 count at which `se0_long_o` asserts; must be >= 1.
- CalibW, 32: calibration bus width; unused in this generic version.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- input_pi  input  1  raw D+
- input_ni  input  1  raw D-
- input_en_i  input  1  receiver enable
- calibration_i  input  CalibW  calibration; unused
- line_state_o  output  2  filtered state {dn,dp}: 00 SE0, 01 J, 10 K, 11 SE1
- rx_d_o  output  1  recovered differential bit: 1 = J, 0 = K
- se0_long_o  output  1  SE0 held >= ResetCycles cycles
- se1_err_o  output  1  sticky SE1 flag (optional feature)
- se1_err_clr_i  input  1  clears `se1_err_o` (optional feature)
- usb_diff_rx_obs_o  output  1  observability copy of `rx_d_o` via `prim_buf`

Behaviour:
- Reset values: `line_state_o`=01 (J), `rx_d_o`=1, `se0_long_o`=0, `se1_err_o`=0, `usb_diff_rx_obs_o`=1; all counters 0.
- Synchroniser: 2-flop `prim_flop_2sync` on {input_ni,input_pi}; sync flops reset to 01.
- Filter operates on the 2-bit vector jointly, so transient SE0/SE1 during J<->K crossover is suppressed.
  - If sync value equals the filtered value, counter is cleared.
  - Otherwise the counter increments.
  - On the edge where the FilterDepth-th consecutive identical differing sample is seen, filtered value <= sync value and counter <= 0.
  - A differing sample that changes value restarts the count at 1.
- Latency from pin to `line_state_o`: 2 + FilterDepth cycles.
- `rx_d_o`: J -> 1, K -> 0; holds its previous value during SE0/SE1.
- SE0 counter: width $clog2(ResetCycles+1).
  - Increments each cycle `line_state_o`==00, saturating at ResetCycles.
  - Cleared on any cycle `line_state_o`!=00.
  - `se0_long_o` = (count==ResetCycles), driven combinationally from the register: rises ResetCycles cycles after SE0 is first output, falls 1 cycle after SE0 ends.
- `input_en_i`=0: synchroniser and filter synchronously forced to 01 and all counters cleared. Outputs read J/1/0 from the next edge and never show SE0. Re-enable restarts the filtering latency.
- Async reset mid-operation returns everything to reset values immediately.
- `calibration_i` is consumed into an unused signal.
- Assertions: FilterDepth>=1, ResetCycles>=1, `line_state_o` known after reset.

Optional Feature:
- Macro: PRIM_USB_RX_SE1_ERR_EN
- Defined:
  - `se1_err_o` sets on any cycle `line_state_o`==11.
  - `se1_err_clr_i` clears it the next cycle.
  - A set in the same cycle as clear wins.
- Undefined: `se1_err_o` tied 0; `se1_err_clr_i` sunk into an unused signal. Port list is identical either way.

Decomposition:
- Package `prim_usb_rx_pkg`:
  - `usb_line_state_e` enum: LsSE0=2'b00, LsJ=2'b01, LsK=2'b10, LsSE1=2'b11.
  - Idle constant `UsbLsIdle`=LsJ.
- Sub-module `prim_usb_rx_glitch_filt`, parametrised Width and Depth, with a synchronous clear and a reset value. Instanced once with Width=2; reusable elsewhere.

Test Plan (FilterDepth=3, ResetCycles=8):
- Apply then release reset, pins dp=1/dn=0 -> `line_state_o`=01, `rx_d_o`=1, `se0_long_o`=0 from the first cycle.
- Drive K (dp=0,dn=1) and hold -> `line_state_o`=10 and `rx_d_o`=0 exactly 5 cycles after the pin change; `usb_diff_rx_obs_o` follows.
- Drive K for 2 cycles then J; also inject a 2-cycle SE0 between J and K -> no change on any output.
- Hold SE0 for 20 cycles -> `line_state_o`=00 at cycle 5, `se0_long_o`=1 at cycle 13 and held. Return to J -> `se0_long_o` falls 1 cycle after `line_state_o`=01.
- Drop `input_en_i` during SE0 at cycle 10 -> next edge `line_state_o`=01 and `se0_long_o`=0. Re-enable with SE0 held -> SE0 reappears 5 cycles later and `se0_long_o` 8 cycles after that.
- With PRIM_USB_RX_SE1_ERR_EN, hold SE1 for 4 cycles -> `se1_err_o`=1 from cycle 6 and stays after return to J. Pulse `se1_err_clr_i` -> 0 next cycle.
- Without PRIM_USB_RX_SE1_ERR_EN, the same stimulus keeps `se1_err_o`=0.
